raster_stamp_unpack: RTL and testbench
======================================

// Module: raster_stamp_unpack
// PURPOSE
//  Consumer end of the rasterizer stamp stream: accepts one 4-lane stamp (pos/edge per lane + coverage
//  mask) per handshake and serializes it into one fragment per covered lane for the fragment/shader
//  dispatch path. Empty stamps are absorbed. Sits between the raster stamp producer and fragment issue.
// PARAMETERS
//  POS_W   16  width of per-lane pos_x/pos_y
//  EDGE_W  32  width of per-lane edge_x/edge_y/edge_z
//  CNT_W   32  width of stamp/fragment statistics counters
// PORTS
//  clk            in   1         clock
//  reset_n        in   1         asynchronous, active-low reset
//  stamp_valid    in   1         input stamp valid
//  stamp_ready    out  1         input stamp accepted when valid&ready
//  stamp_pos_x    in   4*POS_W   lane i at [i*POS_W +: POS_W]
//  stamp_pos_y    in   4*POS_W   lane i as above
//  stamp_edge_x   in   4*EDGE_W  lane i at [i*EDGE_W +: EDGE_W]
//  stamp_edge_y   in   4*EDGE_W  lane i as above
//  stamp_edge_z   in   4*EDGE_W  lane i as above
//  stamp_mask     in   4         lane coverage, bit i = lane i
//  frag_valid     out  1         fragment valid
//  frag_ready     in   1         downstream accepts when valid&ready
//  frag_pos_x/y   out  POS_W     selected lane position
//  frag_edge_x/y/z out EDGE_W    selected lane edge values
//  frag_lane      out  2         lane index within stamp
//  frag_last      out  1         last covered lane of current stamp
//  busy           out  1         stamp held (state EMIT)
//  stamp_cnt      out  CNT_W     stamps accepted (incl. empty)
//  frag_cnt       out  CNT_W     fragments emitted
// BEHAVIOUR
//  - Reset (async assert, sync-released): state IDLE, rem_mask=0, stamp regs=0, frag_valid=0,
//    all frag_* outputs 0, busy=0, stamp_cnt=frag_cnt=0. stamp_ready=1 right after reset.
//  - States: IDLE (no stamp held), EMIT (stamp regs + rem_mask held, rem_mask!=0).
//  - stamp_ready = (state==IDLE) | (state==EMIT & frag_valid & frag_ready & frag_last). Comb. path
//    frag_ready->stamp_ready is intentional (back-to-back stamps, no bubble).
//  - Accept (stamp fire): register all lane data, rem_mask<=stamp_mask, stamp_cnt+=1.
//    mask!=0 -> EMIT; mask==0 -> dropped, state becomes/stays IDLE, no fragment.
//  - EMIT: frag_valid=1; lane = lowest set bit of rem_mask; frag_* = registered fields of that lane;
//    frag_last = (rem_mask has exactly one bit set). Outputs stable while valid & !ready.
//  - Fragment fire: clear selected bit, frag_cnt+=1. If frag_last: same-cycle stamp accept per above
//    (non-empty -> stay EMIT with new stamp; empty or none -> IDLE).
//  - Latency: stamp fire in cycle N -> first fragment valid in N+1; then 1 fragment/cycle under
//    continuous frag_ready; k covered lanes take k cycles; no idle cycle between stamps.
//  - IDLE: frag_valid=0; frag_* data outputs hold 0 (mux of cleared rem_mask).
//  - Counters wrap modulo 2^CNT_W; stamp_cnt and frag_cnt may increment in the same cycle.
//  - Input data is sampled only on stamp fire; changes while !stamp_ready are ignored.
//  - Reset asserted mid-stamp: held stamp discarded, no partial fragments emitted after release.
// TESTING
//  1 mask=4'b1111, pos_x lanes {10,11,12,13}, frag_ready=1 -> 4 frags lanes 0..3, pos_x 10..13,
//    frag_last only on lane 3, stamp_ready high in that 4th cycle; frag_cnt=4, stamp_cnt=1.
//  2 mask=4'b1010 then mask=4'b0001 back-to-back -> frags lanes 1,3(last),0(last) on 3 consecutive
//    cycles, no bubble; stamp_cnt=2, frag_cnt=3.
//  3 mask=4'b0000 with state IDLE -> accepted in 1 cycle, frag_valid stays 0, stamp_cnt=1, frag_cnt=0.
//  4 mask=4'b0110, frag_ready low 5 cycles after first valid -> lane 1 outputs held constant, stamp_ready=0,
//    input changes ignored; on ready -> lanes 1,2 emitted with original data.
//  5 reset_n pulsed low while emitting lane 2 of mask 4'b1111 -> frag_valid=0 immediately (async),
//    counters 0, stamp_ready=1 after release, no stale fragments.
//  6 stamp_cnt preloaded path: drive 2^CNT_W stamps (CNT_W=4 build, 16 empty stamps) -> stamp_cnt wraps to 0.

Source files
------------

// File: rtl/raster_stamp_unpack.sv
// Serializes 4-lane rasterizer stamps into one fragment per covered lane.
// Empty stamps are accepted and dropped; a new stamp can load on the last fragment's cycle.
module raster_stamp_unpack #(
  parameter int POS_W  = 16,
  parameter int EDGE_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                stamp_valid,
  output logic                stamp_ready,
  input  logic [4*POS_W-1:0]  stamp_pos_x,
  input  logic [4*POS_W-1:0]  stamp_pos_y,
  input  logic [4*EDGE_W-1:0] stamp_edge_x,
  input  logic [4*EDGE_W-1:0] stamp_edge_y,
  input  logic [4*EDGE_W-1:0] stamp_edge_z,
  input  logic [3:0]          stamp_mask,
  output logic                frag_valid,
  input  logic                frag_ready,
  output logic [POS_W-1:0]    frag_pos_x,
  output logic [POS_W-1:0]    frag_pos_y,
  output logic [EDGE_W-1:0]   frag_edge_x,
  output logic [EDGE_W-1:0]   frag_edge_y,
  output logic [EDGE_W-1:0]   frag_edge_z,
  output logic [1:0]          frag_lane,
  output logic                frag_last,
  output logic                busy,
  output logic [CNT_W-1:0]    stamp_cnt,
  output logic [CNT_W-1:0]    frag_cnt
);

  // Handshake: a transfer happens on a rising clk edge where valid & ready are both high.
  // Producers keep valid and data stable until the transfer; ready never waits on valid.

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t            state;
  logic [3:0]        rem_mask;
  logic [POS_W-1:0]  px_r [4];
  logic [POS_W-1:0]  py_r [4];
  logic [EDGE_W-1:0] ex_r [4];
  logic [EDGE_W-1:0] ey_r [4];
  logic [EDGE_W-1:0] ez_r [4];

  logic [1:0] sel;
  logic [3:0] sel_bit;
  logic       has_lane;
  logic       stamp_fire;
  logic       frag_fire;

  always_comb begin
    sel = 2'd0;
    if (rem_mask[0])      sel = 2'd0;
    else if (rem_mask[1]) sel = 2'd1;
    else if (rem_mask[2]) sel = 2'd2;
    else if (rem_mask[3]) sel = 2'd3;
  end

  assign sel_bit  = 4'b0001 << sel;
  assign has_lane = |rem_mask;

  // With rem_mask cleared the data mux collapses to zero, so IDLE outputs read 0.
  assign frag_pos_x  = has_lane ? px_r[sel] : '0;
  assign frag_pos_y  = has_lane ? py_r[sel] : '0;
  assign frag_edge_x = has_lane ? ex_r[sel] : '0;
  assign frag_edge_y = has_lane ? ey_r[sel] : '0;
  assign frag_edge_z = has_lane ? ez_r[sel] : '0;
  assign frag_lane   = sel;
  assign frag_last   = has_lane && ((rem_mask & (rem_mask - 4'd1)) == 4'd0);

  assign frag_valid  = (state == EMIT);
  assign busy        = (state == EMIT);
  assign frag_fire   = frag_valid & frag_ready;
  // Ready on the last fragment's fire lets the next stamp load without a bubble.
  assign stamp_ready = (state == IDLE) | (frag_fire & frag_last);
  assign stamp_fire  = stamp_valid & stamp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rem_mask  <= 4'd0;
      stamp_cnt <= '0;
      frag_cnt  <= '0;
      for (int i = 0; i < 4; i++) begin
        px_r[i] <= '0;
        py_r[i] <= '0;
        ex_r[i] <= '0;
        ey_r[i] <= '0;
        ez_r[i] <= '0;
      end
    end else begin
      if (frag_fire) begin
        rem_mask <= rem_mask & ~sel_bit;
        frag_cnt <= frag_cnt + CNT_ONE;
        if (frag_last) state <= IDLE;
      end
      // A stamp accept overrides the clear above; the old stamp is finished by then.
      if (stamp_fire) begin
        rem_mask  <= stamp_mask;
        stamp_cnt <= stamp_cnt + CNT_ONE;
        state     <= (stamp_mask != 4'd0) ? EMIT : IDLE;
        for (int i = 0; i < 4; i++) begin
          px_r[i] <= stamp_pos_x[i*POS_W +: POS_W];
          py_r[i] <= stamp_pos_y[i*POS_W +: POS_W];
          ex_r[i] <= stamp_edge_x[i*EDGE_W +: EDGE_W];
          ey_r[i] <= stamp_edge_y[i*EDGE_W +: EDGE_W];
          ez_r[i] <= stamp_edge_z[i*EDGE_W +: EDGE_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_raster_stamp_unpack.sv
// Bench for raster_stamp_unpack: table vectors, hand-written corner sequences, and a
// randomized run against a fragment-queue reference model.
module tb_raster_stamp_unpack;

  localparam int P  = 16;
  localparam int E  = 32;
  localparam int FW = 2 + 1 + 2*P + 3*E;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic           stamp_valid, stamp_ready, frag_valid, frag_ready;
  logic [4*P-1:0] stamp_pos_x, stamp_pos_y;
  logic [4*E-1:0] stamp_edge_x, stamp_edge_y, stamp_edge_z;
  logic [3:0]     stamp_mask;
  logic [P-1:0]   frag_pos_x, frag_pos_y;
  logic [E-1:0]   frag_edge_x, frag_edge_y, frag_edge_z;
  logic [1:0]     frag_lane;
  logic           frag_last, busy;
  logic [31:0]    stamp_cnt, frag_cnt;

  // narrow-counter instance shares the stamp data inputs
  logic           stamp_valid_w, stamp_ready_w, frag_valid_w, frag_ready_w;
  logic [P-1:0]   frag_pos_x_w, frag_pos_y_w;
  logic [E-1:0]   frag_edge_x_w, frag_edge_y_w, frag_edge_z_w;
  logic [1:0]     frag_lane_w;
  logic           frag_last_w, busy_w;
  logic [3:0]     stamp_cnt_w, frag_cnt_w;

  raster_stamp_unpack u_dut (
    .clk(clk), .reset_n(reset_n),
    .stamp_valid(stamp_valid), .stamp_ready(stamp_ready),
    .stamp_pos_x(stamp_pos_x), .stamp_pos_y(stamp_pos_y),
    .stamp_edge_x(stamp_edge_x), .stamp_edge_y(stamp_edge_y), .stamp_edge_z(stamp_edge_z),
    .stamp_mask(stamp_mask),
    .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_pos_x(frag_pos_x), .frag_pos_y(frag_pos_y),
    .frag_edge_x(frag_edge_x), .frag_edge_y(frag_edge_y), .frag_edge_z(frag_edge_z),
    .frag_lane(frag_lane), .frag_last(frag_last), .busy(busy),
    .stamp_cnt(stamp_cnt), .frag_cnt(frag_cnt)
  );

  raster_stamp_unpack #(.CNT_W(4)) u_dut_w4 (
    .clk(clk), .reset_n(reset_n),
    .stamp_valid(stamp_valid_w), .stamp_ready(stamp_ready_w),
    .stamp_pos_x(stamp_pos_x), .stamp_pos_y(stamp_pos_y),
    .stamp_edge_x(stamp_edge_x), .stamp_edge_y(stamp_edge_y), .stamp_edge_z(stamp_edge_z),
    .stamp_mask(stamp_mask),
    .frag_valid(frag_valid_w), .frag_ready(frag_ready_w),
    .frag_pos_x(frag_pos_x_w), .frag_pos_y(frag_pos_y_w),
    .frag_edge_x(frag_edge_x_w), .frag_edge_y(frag_edge_y_w), .frag_edge_z(frag_edge_z_w),
    .frag_lane(frag_lane_w), .frag_last(frag_last_w), .busy(busy_w),
    .stamp_cnt(stamp_cnt_w), .frag_cnt(frag_cnt_w)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [FW-1:0] exp_q[$];
  logic [31:0]   m_sc, m_fc;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lane data is a fixed function of a per-stamp base value and the lane index.
  function automatic logic [P-1:0] g_px(input logic [15:0] b, input int l);
    return b + P'(l);
  endfunction
  function automatic logic [P-1:0] g_py(input logic [15:0] b, input int l);
    return b + 16'h0100 + P'(3 * l);
  endfunction
  function automatic logic [E-1:0] g_ex(input logic [15:0] b, input int l);
    return {16'hA000 + 16'(l), b};
  endfunction
  function automatic logic [E-1:0] g_ey(input logic [15:0] b, input int l);
    return {b, 16'hB000 + 16'(l)};
  endfunction
  function automatic logic [E-1:0] g_ez(input logic [15:0] b, input int l);
    return {16'hC000 ^ b, 16'(l * 5 + 1)};
  endfunction

  function automatic logic [FW-1:0] frag_of(input logic [15:0] b, input int l, input logic last);
    return {2'(l), last, g_px(b, l), g_py(b, l), g_ex(b, l), g_ey(b, l), g_ez(b, l)};
  endfunction

  function automatic logic [FW-1:0] dut_frag();
    return {frag_lane, frag_last, frag_pos_x, frag_pos_y, frag_edge_x, frag_edge_y, frag_edge_z};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_stamp(input logic v, input logic [3:0] m, input logic [15:0] b);
    stamp_valid = v;
    stamp_mask  = m;
    for (int l = 0; l < 4; l++) begin
      stamp_pos_x[l*P +: P]  = g_px(b, l);
      stamp_pos_y[l*P +: P]  = g_py(b, l);
      stamp_edge_x[l*E +: E] = g_ex(b, l);
      stamp_edge_y[l*E +: E] = g_ey(b, l);
      stamp_edge_z[l*E +: E] = g_ez(b, l);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    frag_ready    = 1'b0;
    stamp_valid_w = 1'b0;
    frag_ready_w  = 1'b0;
    drive_stamp(1'b0, 4'd0, 16'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_sc = 0;
    m_fc = 0;
    @(negedge clk);
  endtask

  task automatic check_frag(input string tag, input int l, input logic last,
                            input logic [15:0] b, input logic sready);
    check({tag, " frag_valid"}, 160'(frag_valid), 160'(1'b1));
    check({tag, " frag_data"}, 160'(dut_frag()), 160'(frag_of(b, l, last)));
    check({tag, " stamp_ready"}, 160'(stamp_ready), 160'(sready));
  endtask

  task automatic check_idle(input string tag);
    check({tag, " idle frag_valid"}, 160'(frag_valid), 160'(1'b0));
    check({tag, " idle frag_data"}, 160'(dut_frag()), 160'(0));
    check({tag, " idle busy"}, 160'(busy), 160'(1'b0));
    check({tag, " idle stamp_ready"}, 160'(stamp_ready), 160'(1'b1));
  endtask

  task automatic check_counts(input string tag);
    check({tag, " stamp_cnt"}, 160'(stamp_cnt), 160'(m_sc));
    check({tag, " frag_cnt"}, 160'(frag_cnt), 160'(m_fc));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  mask;
    logic [15:0] base;
    int          n;
    logic [7:0]  lanes;  // lane of fragment j at [2j +: 2]
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [15:0] b1, b2;
    vecs[0] = '{mask: 4'b1111, base: 16'd10,   n: 4, lanes: 8'hE4};
    vecs[1] = '{mask: 4'b0001, base: 16'h1234, n: 1, lanes: 8'h00};
    vecs[2] = '{mask: 4'b1000, base: 16'h0F00, n: 1, lanes: 8'h03};
    vecs[3] = '{mask: 4'b0101, base: 16'h7777, n: 2, lanes: 8'h08};
    vecs[4] = '{mask: 4'b1110, base: 16'hFFFE, n: 3, lanes: 8'h39};
    vecs[5] = '{mask: 4'b0110, base: 16'h0042, n: 2, lanes: 8'h09};
    vecs[6] = '{mask: 4'b0000, base: 16'h5555, n: 0, lanes: 8'h00};

    do_reset();
    #1;
    check_idle("reset");
    check_counts("reset");
    check("reset stamp_cnt_w4", 160'(stamp_cnt_w), 160'(0));

    // table: each stamp alone from IDLE with frag_ready held high
    frag_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      drive_stamp(1'b1, vecs[v].mask, vecs[v].base);
      #1;
      check($sformatf("vec%0d accept ready", v), 160'(stamp_ready), 160'(1'b1));
      tick();
      m_sc++;
      drive_stamp(1'b0, vecs[v].mask, vecs[v].base);
      for (int j = 0; j < vecs[v].n; j++) begin
        #1;
        check_frag($sformatf("vec%0d f%0d", v, j), int'(vecs[v].lanes[2*j +: 2]),
                   j == vecs[v].n - 1, vecs[v].base, j == vecs[v].n - 1);
        tick();
        m_fc++;
      end
      #1;
      check_idle($sformatf("vec%0d end", v));
      check_counts($sformatf("vec%0d end", v));
    end

    // back-to-back stamps 1010 then 0001, no bubble
    b1 = 16'h2000;
    b2 = 16'h3000;
    drive_stamp(1'b1, 4'b1010, b1);
    tick();
    drive_stamp(1'b1, 4'b0001, b2);
    #1 check_frag("b2b l1", 1, 1'b0, b1, 1'b0);
    tick();
    #1 check_frag("b2b l3", 3, 1'b1, b1, 1'b1);
    tick();
    drive_stamp(1'b0, 4'b0001, b2);
    #1 check_frag("b2b l0", 0, 1'b1, b2, 1'b1);
    tick();
    m_sc += 2;
    m_fc += 3;
    #1 check_idle("b2b end");
    check_counts("b2b end");

    // empty stamp from IDLE
    drive_stamp(1'b1, 4'b0000, 16'h4444);
    #1 check("empty ready", 160'(stamp_ready), 160'(1'b1));
    tick();
    drive_stamp(1'b0, 4'b0000, 16'h4444);
    m_sc++;
    #1 check_idle("empty");
    check_counts("empty");

    // backpressure with input churn: held lane 1 must keep its original data
    b1 = 16'h6000;
    drive_stamp(1'b1, 4'b0110, b1);
    tick();
    frag_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive_stamp(1'b1, 4'($urandom_range(1, 15)), 16'($urandom));
      #1 check_frag($sformatf("hold c%0d", c), 1, 1'b0, b1, 1'b0);
      tick();
    end
    frag_ready = 1'b1;
    drive_stamp(1'b0, 4'b0000, 16'h0);
    #1 check_frag("hold rel l1", 1, 1'b0, b1, 1'b0);
    tick();
    #1 check_frag("hold rel l2", 2, 1'b1, b1, 1'b1);
    tick();
    m_sc++;
    m_fc += 2;
    #1 check_idle("hold end");
    check_counts("hold end");

    // reset asserted while lane 2 of a full stamp is presented
    b1 = 16'h7100;
    drive_stamp(1'b1, 4'b1111, b1);
    tick();
    drive_stamp(1'b0, 4'b1111, b1);
    #1 check_frag("rst l0", 0, 1'b0, b1, 1'b0);
    tick();
    #1 check_frag("rst l1", 1, 1'b0, b1, 1'b0);
    tick();
    #1 check_frag("rst l2", 2, 1'b0, b1, 1'b0);
    reset_n = 1'b0;
    m_sc = 0;
    m_fc = 0;
    #1 check("rst async frag_valid", 160'(frag_valid), 160'(1'b0));
    check_counts("rst async");
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check_idle($sformatf("rst post c%0d", c));
      check_counts("rst post");
      tick();
    end

    // 4-bit counter wrap after 16 empty stamps
    do_reset();
    drive_stamp(1'b0, 4'b0000, 16'h0);
    stamp_valid_w = 1'b1;
    frag_ready_w  = 1'b1;
    repeat (15) tick();
    #1 check("wrap cnt15", 160'(stamp_cnt_w), 160'(15));
    tick();
    stamp_valid_w = 1'b0;
    #1 check("wrap cnt0", 160'(stamp_cnt_w), 160'(0));
    check("wrap frag_valid", 160'(frag_valid_w), 160'(1'b0));
    check("wrap frag_cnt", 160'(frag_cnt_w), 160'(0));

    // randomized run against the fragment-queue model
    do_reset();
    exp_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic        rv, m_ready;
      logic [3:0]  rm;
      logic [15:0] rb;
      rv = ($urandom_range(0, 3) != 0);
      rm = 4'($urandom_range(0, 15));
      rb = 16'($urandom);
      drive_stamp(rv, rm, rb);
      frag_ready = ($urandom_range(0, 3) != 0);
      #1;
      m_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && frag_ready);
      check("rnd stamp_ready", 160'(stamp_ready), 160'(m_ready));
      check("rnd frag_valid", 160'(frag_valid), 160'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("rnd frag_data", 160'(dut_frag()), 160'(exp_q[0]));
      else check("rnd idle data", 160'(dut_frag()), 160'(0));
      check_counts("rnd");
      if (exp_q.size() != 0 && frag_ready) begin
        void'(exp_q.pop_front());
        m_fc++;
      end
      if (rv && m_ready) begin
        m_sc++;
        for (int l = 0; l < 4; l++)
          if (rm[l]) exp_q.push_back(frag_of(rb, l, (rm >> (l + 1)) == 4'd0));
      end
      tick();
    end
    #1 check_counts("rnd end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
